// File: rtl/serial_frame_tx_if.sv
// serial_frame_tx_if: load handshake and serial line of the framed transmitter
interface serial_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] din;
    logic              load;
    logic              ready;
    logic              q;
    logic              busy;
    logic              done;
    modport master (output din, load, input ready, q, busy, done);
    modport slave (input din, load, output ready, q, busy, done);
endinterface

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-in framed serial transmitter (start 0, data LSB first, stop 1)
module serial_frame_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input logic             CLK,
    input logic             RST,
    serial_frame_tx_if.slave tx
);
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [BW-1:0]     bit_q;
    logic [DATA_W-1:0] sh_q;
    logic [DATA_W-1:0] sh_d;
    logic              q_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;
    logic              bit_end;
    assign bit_end = cnt_q == CNT_LAST;
    assign sh_d    = sh_q >> 1;
    // Frame sequencer; Q is loaded with the level of the bit about to start so it stays registered
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            q_q     <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tx.load) begin
                        sh_q    <= tx.din;
                        cnt_q   <= '0;
                        state_q <= START;
                        q_q     <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= DATA;
                        q_q     <= sh_q[0];
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        sh_q  <= sh_d;
                        if (bit_q == BIT_LAST) begin
                            state_q <= STOP;
                            q_q     <= 1'b1;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                            q_q   <= sh_d[0];
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        q_q     <= 1'b1;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign tx.q     = q_q;
    assign tx.ready = ready_q;
    assign tx.busy  = busy_q;
    assign tx.done  = done_q;
endmodule
